// File: rtl/param_nr_divider.sv
// ---------------------------------------------------------------------------
// param_nr_divider
//
// Multi-cycle non-restoring integer divider. It produces one quotient bit per
// cycle for signed (two's-complement) or unsigned operands of WIDTH bits.
// Divide-by-zero and signed-overflow results follow the RISC-V M extension.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active high
//   clk_en_i       clock enable; all state holds while low
//   start_i        request, accepted when ready_o is high (in IDLE)
//   ready_o        high in IDLE only
//   signed_i       1 = signed operands, sampled at accept
//   dividend_i     dividend, sampled at accept
//   divisor_i      divisor, sampled at accept
//   abort_i        cancels the operation in DIVIDE / RESTORE / DONE
//   quotient_o     quotient, qualified by valid_o
//   remainder_o    remainder, qualified by valid_o
//   valid_o        result available, held until ack_i
//   ack_i          consumer takes the result
//   zero_divide_o  divisor was zero, qualified by valid_o
//   overflow_o     signed MIN / -1, qualified by valid_o
//
// Configuration macro NR_DIV_REMAINDER_EN
//   defined   : a RESTORE cycle fixes up the partial remainder and remainder_o
//               carries the remainder (normal latency WIDTH+2 edges).
//   undefined : no RESTORE state, the quotient is finished in the last DIVIDE
//               cycle and remainder_o is tied to zero (latency WIDTH+1 edges).
// ---------------------------------------------------------------------------
module param_nr_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_en_i,
  input  logic             start_i,
  output logic             ready_o,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             valid_o,
  input  logic             ack_i,
  output logic             zero_divide_o,
  output logic             overflow_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, RESTORE, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;       // signed partial remainder
  logic [WIDTH-1:0] a_q, a_d;       // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] b_q, b_d;       // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             zdiv_q, zdiv_d;
  logic             ovf_q, ovf_d;
`ifdef NR_DIV_REMAINDER_EN
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   p_fix;
`endif

  // One non-restoring step: shift {P, A} left, then add or subtract B
  // depending on the sign of the old P; the new quotient bit is ~sign(P).
  logic [WIDTH:0]   b_ext, p_shift, p_step;
  logic [WIDTH-1:0] a_step, dvd_mag, dvs_mag;
  logic             dvd_neg, dvs_neg;

  assign b_ext   = {1'b0, b_q};
  assign p_shift = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign p_step  = p_q[WIDTH] ? (p_shift + b_ext) : (p_shift - b_ext);
  assign a_step  = {a_q[WIDTH-2:0], ~p_step[WIDTH]};

  assign dvd_neg = signed_i & dividend_i[WIDTH-1];
  assign dvs_neg = signed_i & divisor_i[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag = dvs_neg ? -divisor_i  : divisor_i;

`ifdef NR_DIV_REMAINDER_EN
  assign p_fix = p_q[WIDTH] ? (p_q + b_ext) : p_q;
`endif

  always_comb begin
    // NOTE: every _d starts as a copy of its _q so each path through the case
    // assigns it; a missing default here would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    a_d     = a_q;
    b_d     = b_q;
    q_neg_d = q_neg_q;
    quot_d  = quot_q;
    valid_d = valid_q;
    ready_d = ready_q;
    zdiv_d  = zdiv_q;
    ovf_d   = ovf_q;
`ifdef NR_DIV_REMAINDER_EN
    r_neg_d = r_neg_q;
    rem_d   = rem_q;
`endif

    if (clk_en_i) begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            ready_d = 1'b0;
            zdiv_d  = 1'b0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            if (divisor_i == '0) begin
              // Divide by zero completes immediately.
              state_d = DONE;
              valid_d = 1'b1;
              zdiv_d  = 1'b1;
              quot_d  = '1;
`ifdef NR_DIV_REMAINDER_EN
              rem_d   = dividend_i;
`endif
            end else if (signed_i && dividend_i == MIN_VAL && divisor_i == '1) begin
              // MIN / -1 has no representable quotient.
              state_d = DONE;
              valid_d = 1'b1;
              ovf_d   = 1'b1;
              quot_d  = dividend_i;
`ifdef NR_DIV_REMAINDER_EN
              rem_d   = '0;
`endif
            end else begin
              state_d = DIVIDE;
              p_d     = '0;
              a_d     = dvd_mag;
              b_d     = dvs_mag;
              q_neg_d = dvd_neg ^ dvs_neg;
`ifdef NR_DIV_REMAINDER_EN
              r_neg_d = dvd_neg;
`endif
            end
          end
        end

        DIVIDE: begin
          if (abort_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
          end else begin
            p_d   = p_step;
            a_d   = a_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
`ifdef NR_DIV_REMAINDER_EN
              state_d = RESTORE;
`else
              // No restore cycle: the quotient is final after this step.
              state_d = DONE;
              valid_d = 1'b1;
              quot_d  = q_neg_q ? -a_step : a_step;
`endif
            end
          end
        end

`ifdef NR_DIV_REMAINDER_EN
        RESTORE: begin
          if (abort_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
          end else begin
            state_d = DONE;
            valid_d = 1'b1;
            quot_d  = q_neg_q ? -a_q : a_q;
            rem_d   = r_neg_q ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
          end
        end
`endif

        DONE: begin
          if (abort_i || ack_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the values computed before this edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_neg_q <= 1'b0;
      quot_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      zdiv_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef NR_DIV_REMAINDER_EN
      r_neg_q <= 1'b0;
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_neg_q <= q_neg_d;
      quot_q  <= quot_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      zdiv_q  <= zdiv_d;
      ovf_q   <= ovf_d;
`ifdef NR_DIV_REMAINDER_EN
      r_neg_q <= r_neg_d;
      rem_q   <= rem_d;
`endif
    end
  end

  assign ready_o       = ready_q;
  assign valid_o       = valid_q;
  assign quotient_o    = quot_q;
  assign zero_divide_o = zdiv_q;
  assign overflow_o    = ovf_q;
`ifdef NR_DIV_REMAINDER_EN
  assign remainder_o   = rem_q;
`else
  assign remainder_o   = '0;
`endif

endmodule

// File: tb/tb_param_nr_divider.sv
// ---------------------------------------------------------------------------
// tb_param_nr_divider
//
// Directed testbench for param_nr_divider at WIDTH = 32. Expected results
// come from a behavioural division model and are queued when an operation is
// driven, then popped and compared when valid_o rises. Inputs change on the
// falling edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_param_nr_divider;

  localparam int W = 32;
`ifdef NR_DIV_REMAINDER_EN
  localparam int LAT_N  = W + 2;
  localparam bit REM_EN = 1'b1;
`else
  localparam int LAT_N  = W + 1;
  localparam bit REM_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         zd;
    logic         ov;
    int           lat;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         clk_en_i = 1'b1;
  logic         start_i = 1'b0;
  logic         ready_o;
  logic         signed_i = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic         abort_i = 1'b0;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         valid_o;
  logic         ack_i = 1'b1;
  logic         zero_divide_o;
  logic         overflow_o;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  param_nr_divider #(.WIDTH(W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clk_en_i      (clk_en_i),
    .start_i       (start_i),
    .ready_o       (ready_o),
    .signed_i      (signed_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .abort_i       (abort_i),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .valid_o       (valid_o),
    .ack_i         (ack_i),
    .zero_divide_o (zero_divide_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // RISC-V division semantics, written independently of the datapath.
  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.zd  = 1'b0;
    e.ov  = 1'b0;
    e.lat = LAT_N;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.zd  = 1'b1;
      e.lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q   = a;
      e.r   = '0;
      e.ov  = 1'b1;
      e.lat = 1;
    end else if (s) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    if (!REM_EN) e.r = '0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with ready_o high; returns at the falling edge
  // right after the accepting rising edge (edge 1 of the operation).
  task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push);
    signed_i   = s;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    if (push) sb.push_back(model(s, a, b));
    @(negedge clk_i);
    start_i    = 1'b0;
    signed_i   = $urandom_range(1);
    dividend_i = $urandom;
    divisor_i  = $urandom;
  endtask

  // Waits (bounded) for valid_o, checks latency and result against the
  // scoreboard, and, when ack_i is high, checks the return to IDLE.
  task automatic wait_result(input string tag);
    exp_t e;
    int   n = 1;
    while (valid_o !== 1'b1 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, 64'(valid_o), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(e.lat));
    chk({tag, "_quot"}, 64'(quotient_o), 64'(e.q));
    chk({tag, "_rem"}, 64'(remainder_o), 64'(e.r));
    chk({tag, "_zdiv"}, 64'(zero_divide_o), 64'(e.zd));
    chk({tag, "_ovf"}, 64'(overflow_o), 64'(e.ov));
    if (ack_i) begin
      @(negedge clk_i);
      chk({tag, "_ready_after"}, 64'(ready_o), 64'd1);
      chk({tag, "_valid_after"}, 64'(valid_o), 64'd0);
    end
  endtask

  initial begin
    exp_t h;
    bit   seen;

    // Reset state.
    repeat (3) @(negedge clk_i);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_zdiv", 64'(zero_divide_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_quot", 64'(quotient_o), 64'd0);
    chk("rst_rem", 64'(remainder_o), 64'd0);
    rst_i = 1'b0;

    // Main function, back-to-back with ack_i held high.
    start_op(1'b0, 32'd100, 32'd7, 1'b1);                 wait_result("u_100_7");
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);           wait_result("s_m7_2");
    start_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1);           wait_result("u_fff9_2");
    start_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);           wait_result("s_7_m2");
    start_op(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1);   wait_result("s_m8_m3");
    start_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);           wait_result("u_max_1");
    start_op(1'b0, 32'd3, 32'hFFFF_FFFF, 1'b1);           wait_result("u_3_max");
    start_op(1'b1, 32'h8000_0000, 32'd2, 1'b1);           wait_result("s_min_2");

    // Exceptions.
    start_op(1'b0, 32'd5, 32'd0, 1'b1);                   wait_result("u_div0");
    start_op(1'b1, 32'd5, 32'd0, 1'b1);                   wait_result("s_div0");
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   wait_result("s_ovf");

    // A few random operands.
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = (i[0]) ? 32'($urandom_range(1, 1000)) : $urandom;
      start_op(1'(i >> 1), ra, rb, 1'b1);
      wait_result("rand");
    end

    // Result held in DONE while ack_i is low, with clk_en_i toggling and
    // start_i asserted; none of that may disturb the result.
    ack_i = 1'b0;
    h = model(1'b0, 32'd1234, 32'd5);
    start_op(1'b0, 32'd1234, 32'd5, 1'b1);
    wait_result("hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      clk_en_i   = i[0];
      start_i    = 1'b1;
      dividend_i = $urandom;
      divisor_i  = 32'd1;
      chk("hold_valid", 64'(valid_o), 64'd1);
      chk("hold_ready", 64'(ready_o), 64'd0);
      chk("hold_quot", 64'(quotient_o), 64'(h.q));
      chk("hold_rem", 64'(remainder_o), 64'(h.r));
    end
    @(negedge clk_i);
    clk_en_i = 1'b1;
    start_i  = 1'b0;
    ack_i    = 1'b1;
    @(negedge clk_i);
    chk("ack_ready", 64'(ready_o), 64'd1);
    chk("ack_valid", 64'(valid_o), 64'd0);
    start_op(1'b0, 32'd77, 32'd4, 1'b1);
    wait_result("after_hold");

    // Abort in the fifth DIVIDE cycle: no result ever appears.
    start_op(1'b1, 32'hFFFF_FC18, 32'd7, 1'b0);
    repeat (4) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("abort_ready", 64'(ready_o), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);

    // Reset in the twelfth DIVIDE cycle of a new operation.
    start_op(1'b0, 32'd99999, 32'd3, 1'b0);
    repeat (11) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("midrst_ready", 64'(ready_o), 64'd1);
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_quot", 64'(quotient_o), 64'd0);
    chk("midrst_rem", 64'(remainder_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);
    chk("midrst_ready_idle", 64'(ready_o), 64'd1);

    start_op(1'b0, 32'd1000, 32'd10, 1'b1);
    wait_result("u_1000_10");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/param_nr_divider.md
# param_nr_divider

Parametrised, multi-cycle non-restoring integer divider producing quotient and remainder for signed or unsigned operands, one quotient bit per cycle. It is the general-purpose successor of the fixed 32-bit divider: it serves the M-extension DIV/DIVU/REM/REMU path and the FPU mantissa divider (WIDTH set per instance). It uses a start/ready input handshake and a valid/ack output handshake, implements RISC-V divide-by-zero and overflow semantics, and supports abort.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- clk_en_i  in  1  clock enable; when low all state and registers hold.
- start_i  in  1  request; accepted on a rising edge with start_i & ready_o & clk_en_i.
- ready_o  out  1  high in IDLE only.
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- dividend_i  in  WIDTH  dividend, sampled at accept.
- divisor_i  in  WIDTH  divisor, sampled at accept.
- abort_i  in  1  cancel the operation in flight.
- quotient_o  out  WIDTH  quotient, valid while valid_o.
- remainder_o  out  WIDTH  remainder, valid while valid_o.
- valid_o  out  1  result available; held until ack_i.
- ack_i  in  1  consumer takes the result; effective when valid_o & ack_i & clk_en_i.
- zero_divide_o  out  1  divisor was zero; qualified by valid_o.
- overflow_o  out  1  signed MIN / -1; qualified by valid_o.

## Operation
- States: IDLE, DIVIDE, RESTORE, DONE.
- IDLE -> DIVIDE on accept. Exception: a zero divisor or a signed overflow goes IDLE -> DONE directly.
- At accept, register the operand magnitudes: |x| when signed_i and the MSB is set, else x.
- Also register the quotient sign (sign(a)^sign(b)) and the remainder sign (sign(a)) for signed operations.
- Counter clears to 0 at accept.
- DIVIDE, per cycle:
  - shift {P, A} left by 1;
  - if the old P is negative, P = P_shift + B, else P = P_shift - B;
  - A[0] = ~new P[WIDTH].
  - P is WIDTH+1 bits; B is zero-extended to WIDTH+1.
  - Counter increments; leave DIVIDE when counter == WIDTH-1 (exactly WIDTH DIVIDE cycles).
- RESTORE (one cycle): if P is negative, P = P + B. Then apply the quotient and remainder sign corrections (two's-complement negate) into the result registers.
- DONE: valid_o = 1; results are stable. On ack, go to DONE -> IDLE.
- Divide by zero: quotient_o = all ones, remainder_o = dividend_i, zero_divide_o = 1. Applies to both signed and unsigned.
- Signed overflow (dividend = 100..0, divisor = all ones, signed_i = 1): quotient_o = dividend, remainder_o = 0, overflow_o = 1.
- abort_i with clk_en_i in DIVIDE, RESTORE or DONE: next state is IDLE and valid_o drops; no result is delivered. abort_i is ignored in IDLE, and start_i is not accepted on the abort edge.
- Inputs other than start_i, abort_i and ack_i may change freely after accept.

## Timing
- Normal latency: valid_o rises WIDTH+2 edges after the accepting edge (WIDTH in DIVIDE, 1 in RESTORE). WIDTH=32 gives 34.
- Exception latency: valid_o rises 1 edge after accept.
- Throughput: ack in DONE returns to IDLE; ready_o is high the next cycle. Minimum initiation interval is WIDTH+3 cycles.
- ack_i low holds DONE indefinitely with outputs stable.
- clk_en_i low stretches every phase cycle-for-cycle.
- Reset: asynchronous; state = IDLE and all data registers = 0. Output values:
  - ready_o = 1;
  - valid_o = 0, zero_divide_o = 0, overflow_o = 0;
  - quotient_o = 0, remainder_o = 0.
- Reset asserted mid-operation discards the operation. The first accept is possible on the first edge after reset deasserts.

## Configuration
- Macro NR_DIV_REMAINDER_EN.
- Defined: behaviour exactly as above.
- Undefined:
  - RESTORE state is omitted; DIVIDE -> DONE, and sign correction moves into the last DIVIDE cycle.
  - Normal latency becomes WIDTH+1.
  - remainder_o is tied to 0, including for divide-by-zero.
  - quotient_o values are unchanged.

## Test plan
- Unsigned, WIDTH=32, 100 / 7, ack_i held high -> quotient_o=14, remainder_o=2, valid_o high exactly 34 edges after accept, then ready_o high next cycle.
- Signed -7 / 2 -> quotient_o=0xFFFFFFFD (-3), remainder_o=0xFFFFFFFF (-1). Unsigned 0xFFFFFFF9 / 2 -> quotient_o=0x7FFFFFFC, remainder_o=1.
- 5 / 0 (signed and unsigned) -> quotient_o=0xFFFFFFFF, remainder_o=5, zero_divide_o=1, valid_o one edge after accept.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient_o=0x80000000, remainder_o=0, overflow_o=1.
- ack_i low for 10 cycles in DONE with clk_en_i toggling -> outputs stable, ready_o=0, start_i ignored. Then ack_i high -> next op accepted 1 cycle later.
- abort_i at DIVIDE cycle 5, then rst_i pulsed at DIVIDE cycle 12 of a new op -> no valid_o in either case. After reset, outputs are 0 and ready_o=1 immediately; a following 1000 / 10 returns 100 r 0.
